// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data RAM responder slice.
// Holds the bus widths of the MEM-stage RAM interface (data, address and
// byte-lane select buses), the wait-state counter width and the responder
// FSM state encoding.
package data_ram_responder_pkg;

   localparam int unsigned DATA_BUS_W = 32;  // load/store data bus
   localparam int unsigned ADDR_BUS_W = 32;  // byte address bus
   localparam int unsigned MEM_SEL_W  = 4;   // byte-lane write enables
   localparam int unsigned WAIT_CNT_W = 4;   // holds WAIT_CYCLES 0..15

   typedef enum logic [1:0] {
      DRAM_IDLE = 2'd0,
      DRAM_WAIT = 2'd1,
      DRAM_RESP = 2'd2
   } dram_state_t;

   // Byte-lane merge: lane i of the result comes from new_word when sel[i] is set.
   function automatic logic [DATA_BUS_W-1:0] merge_lanes(
      input logic [DATA_BUS_W-1:0] old_word,
      input logic [DATA_BUS_W-1:0] new_word,
      input logic [MEM_SEL_W-1:0]  sel
   );
      logic [DATA_BUS_W-1:0] res;
      res = old_word;
      for (int unsigned i = 0; i < MEM_SEL_W; i++) begin
         if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_ram_responder_array.sv
// data_ram_array: word-organised storage for the data RAM responder.
// 2**ADDR_WIDTH x 32-bit words with four byte-lane write enables and a
// synchronous read port whose output register resets to zero.
// Ports:
//   clk      in   clock
//   rst      in   async active-high reset (read register only, not the array)
//   wr_en    in   byte-lane write enables; any bit set performs a write
//   rd_en    in   load rd_data with the addressed word at this edge
//   rd_clr   in   clear rd_data at this edge (rejected access)
//   addr     in   word index
//   wr_data  in   lane-positioned write data
//   rd_data  out  registered read word (held when no read/clear)
module data_ram_array
   import data_ram_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MEM_SEL_W-1:0]  wr_en,
   input  logic                  rd_en,
   input  logic                  rd_clr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_BUS_W-1:0] wr_data,
   output logic [DATA_BUS_W-1:0] rd_data
);

   logic [DATA_BUS_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (|wr_en) mem[addr] <= merge_lanes(mem[addr], wr_data, wr_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rd_data <= '0;
      else if (rd_clr) rd_data <= '0;
      else if (rd_en)  rd_data <= mem[addr];
   end

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: memory-side responder for the MEM-stage RAM interface.
// Latches a request, optionally waits WAIT_CYCLES extra cycles (stalling the
// pipeline), performs the access against data_ram_array and pulses
// ram_resp_valid for one cycle with the registered read word.
// Optional feature macro: DATA_RAM_ERR_EN -- adds ram_addr_err and rejects
// accesses whose address bits above the RAM capacity are non-zero.
// Ports:
//   clk             in   clock
//   rst             in   async active-high reset
//   ram_en          in   request valid (held while ram_stall=1)
//   ram_write_en    in   byte-lane write enables, 0 = read
//   ram_addr        in   byte address, bits[1:0] ignored
//   ram_write_data  in   lane-positioned store data
//   ram_read_data   out  registered read word, valid with ram_resp_valid
//   ram_stall       out  pipeline must hold the MEM request
//   ram_resp_valid  out  one-cycle access-complete pulse
//   ram_addr_err    out  (DATA_RAM_ERR_EN only) out-of-range address, in RESP
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ram_en,
   input  logic [MEM_SEL_W-1:0]  ram_write_en,
   input  logic [ADDR_BUS_W-1:0] ram_addr,
   input  logic [DATA_BUS_W-1:0] ram_write_data,
   output logic [DATA_BUS_W-1:0] ram_read_data,
   output logic                  ram_stall,
   output logic                  ram_resp_valid
`ifdef DATA_RAM_ERR_EN
  ,output logic                  ram_addr_err
`endif
);

   dram_state_t            state;
   logic [WAIT_CNT_W-1:0]  cnt;
   logic [ADDR_WIDTH-1:0]  lat_idx;
   logic [MEM_SEL_W-1:0]   lat_we;
   logic [DATA_BUS_W-1:0]  lat_wd;
   logic                   lat_err;

   logic                   live_err;
   logic                   fire;
   logic                   acc_err;
   logic [ADDR_WIDTH-1:0]  acc_idx;
   logic [MEM_SEL_W-1:0]   acc_we;
   logic [DATA_BUS_W-1:0]  acc_wd;
   logic [MEM_SEL_W-1:0]   arr_wr_en;
   logic                   arr_rd_en;
   logic                   arr_rd_clr;
   logic                   unused_addr;

`ifdef DATA_RAM_ERR_EN
   assign live_err = |ram_addr[ADDR_BUS_W-1:ADDR_WIDTH+2];
`else
   assign live_err = 1'b0;
`endif
   assign unused_addr = ^{ram_addr[1:0], ram_addr[ADDR_BUS_W-1:ADDR_WIDTH+2]};

   assign ram_stall = ram_en & (state != DRAM_RESP) & ~rst;

   // With no wait states the access happens at the same edge that latches the
   // request, so the live inputs stand in for the (identical) latched values.
   always_comb begin
      fire    = 1'b0;
      acc_idx = lat_idx;
      acc_we  = lat_we;
      acc_wd  = lat_wd;
      acc_err = lat_err;
      if (state == DRAM_IDLE) begin
         fire    = ram_en && (WAIT_CYCLES == 0);
         acc_idx = ram_addr[ADDR_WIDTH+1:2];
         acc_we  = ram_write_en;
         acc_wd  = ram_write_data;
         acc_err = live_err;
      end else if (state == DRAM_WAIT) begin
         fire = ram_en && (cnt == WAIT_CNT_W'(1));
      end
   end

   always_comb begin
      arr_wr_en  = '0;
      arr_rd_en  = 1'b0;
      arr_rd_clr = 1'b0;
      if (fire) begin
         if (acc_err)      arr_rd_clr = 1'b1;
         else if (|acc_we) arr_wr_en  = acc_we;
         else              arr_rd_en  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= DRAM_IDLE;
         cnt            <= '0;
         lat_idx        <= '0;
         lat_we         <= '0;
         lat_wd         <= '0;
         lat_err        <= 1'b0;
         ram_resp_valid <= 1'b0;
`ifdef DATA_RAM_ERR_EN
         ram_addr_err   <= 1'b0;
`endif
      end else begin
         ram_resp_valid <= 1'b0;
`ifdef DATA_RAM_ERR_EN
         ram_addr_err   <= 1'b0;
`endif
         case (state)
            DRAM_IDLE: begin
               if (ram_en) begin
                  lat_idx <= ram_addr[ADDR_WIDTH+1:2];
                  lat_we  <= ram_write_en;
                  lat_wd  <= ram_write_data;
                  lat_err <= live_err;
                  if (WAIT_CYCLES == 0) begin
                     state          <= DRAM_RESP;
                     ram_resp_valid <= 1'b1;
`ifdef DATA_RAM_ERR_EN
                     ram_addr_err   <= live_err;
`endif
                  end else begin
                     cnt   <= WAIT_CNT_W'(WAIT_CYCLES);
                     state <= DRAM_WAIT;
                  end
               end
            end
            DRAM_WAIT: begin
               if (!ram_en) begin
                  // pipeline flush: drop the pending access entirely
                  cnt   <= '0;
                  state <= DRAM_IDLE;
               end else if (cnt == WAIT_CNT_W'(1)) begin
                  cnt            <= '0;
                  state          <= DRAM_RESP;
                  ram_resp_valid <= 1'b1;
`ifdef DATA_RAM_ERR_EN
                  ram_addr_err   <= lat_err;
`endif
               end else begin
                  cnt <= cnt - WAIT_CNT_W'(1);
               end
            end
            DRAM_RESP: state <= DRAM_IDLE;
            default:   state <= DRAM_IDLE;
         endcase
      end
   end

   data_ram_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (arr_wr_en),
      .rd_en   (arr_rd_en),
      .rd_clr  (arr_rd_clr),
      .addr    (acc_idx),
      .wr_data (acc_wd),
      .rd_data (ram_read_data)
   );

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (WAIT_CYCLES 0 and 3) driven one
// at a time. The driver records the expected per-cycle output timeline of each
// transaction in a queue; a negedge process compares both DUTs against it.
module tb_data_ram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en    [2];
   logic [3:0]  we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        stall [2];
   logic        rv    [2];
`ifdef DATA_RAM_ERR_EN
   logic        aerr  [2];
   localparam bit ERR_BUILD = 1'b1;
`else
   localparam bit ERR_BUILD = 1'b0;
`endif

   always #5 clk = ~clk;

   data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .ram_en(en[0]), .ram_write_en(we[0]),
      .ram_addr(addr[0]), .ram_write_data(wd[0]), .ram_read_data(rdata[0]),
      .ram_stall(stall[0]), .ram_resp_valid(rv[0])
`ifdef DATA_RAM_ERR_EN
     ,.ram_addr_err(aerr[0])
`endif
   );

   data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst), .ram_en(en[1]), .ram_write_en(we[1]),
      .ram_addr(addr[1]), .ram_write_data(wd[1]), .ram_read_data(rdata[1]),
      .ram_stall(stall[1]), .ram_resp_valid(rv[1])
`ifdef DATA_RAM_ERR_EN
     ,.ram_addr_err(aerr[1])
`endif
   );

   typedef struct {
      int          sel;
      logic        stall;
      logic        rv;
      logic        chk;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        q [$];
   logic [31:0] mref    [2][1024];
   logic [31:0] last_rd [2];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         for (int d = 0; d < 2; d++) begin
            if (d == e.sel) begin
               check($sformatf("stall[d%0d]", d), 32'(stall[d]), 32'(e.stall));
               check($sformatf("resp_valid[d%0d]", d), 32'(rv[d]), 32'(e.rv));
               if (e.chk) check($sformatf("read_data[d%0d]", d), rdata[d], e.data);
`ifdef DATA_RAM_ERR_EN
               check($sformatf("addr_err[d%0d]", d), 32'(aerr[d]), 32'(e.err));
`endif
            end else begin
               check($sformatf("idle_stall[d%0d]", d), 32'(stall[d]), 32'd0);
               check($sformatf("idle_resp_valid[d%0d]", d), 32'(rv[d]), 32'd0);
            end
         end
      end
   end

   function automatic int wait_of(input int sel);
      return (sel == 1) ? 3 : 0;
   endfunction

   task automatic drive(input int sel, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < 2; i++) begin
         en[i] = 1'b0; we[i] = '0; addr[i] = '0; wd[i] = '0;
      end
      en[sel] = e; we[sel] = w; addr[sel] = a; wd[sel] = d;
   endtask

   task automatic push(input int sel, input logic s, input logic r, input logic c,
                       input logic [31:0] d, input logic er);
      exp_t e;
      e.sel = sel; e.stall = s; e.rv = r; e.chk = c; e.data = d; e.err = er;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
      push(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
   endtask

   // One request as the pipeline sees it: stall for WAIT+1 cycles, then the
   // response cycle. flush_at >= 1 drops ram_en on that wait cycle instead.
   task automatic access(input int sel, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, input int flush_at,
                         input logic use_lit, input logic [31:0] lit);
      int          nw;
      int          idx;
      logic        err;
      logic [31:0] rexp;
      nw  = wait_of(sel);
      idx = int'(a[11:2]);
      err = ERR_BUILD && (a[31:12] != 20'h0);
      for (int k = 0; k <= nw; k++) begin
         if (k == flush_at) begin
            drive(sel, 1'b0, w, a, d);
            push(sel, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
            return;
         end
         drive(sel, 1'b1, w, a, d);
         push(sel, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
         tick();
      end
      if (err) begin
         last_rd[sel] = 32'h0;
      end else if (w != 4'h0) begin
         for (int i = 0; i < 4; i++)
            if (w[i]) mref[sel][idx][8*i +: 8] = d[8*i +: 8];
      end else begin
         last_rd[sel] = mref[sel][idx];
      end
      rexp = use_lit ? lit : last_rd[sel];
      drive(sel, 1'b0, 4'h0, 32'h0, 32'h0);
      push(sel, 1'b0, 1'b1, 1'b1, rexp, err);
      tick();
   endtask

   initial begin
      int          sel;
      int          fl;
      logic [19:0] hi;
      logic [9:0]  idx;
      logic [1:0]  lo;
      logic [3:0]  w;
      logic [31:0] a;

      // reset with a request pending: stall must be forced low
      rst = 1'b1;
      drive(0, 1'b1, 4'h0, 32'h0, 32'h0);
      en[1] = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_stall[d%0d]", d), 32'(stall[d]), 32'd0);
         check($sformatf("rst_resp_valid[d%0d]", d), 32'(rv[d]), 32'd0);
         check($sformatf("rst_read_data[d%0d]", d), rdata[d], 32'h0);
`ifdef DATA_RAM_ERR_EN
         check($sformatf("rst_addr_err[d%0d]", d), 32'(aerr[d]), 32'd0);
`endif
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;

      // give words 0..63 of both RAMs known contents
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 64; i++)
            access(s, 32'(i * 4), 4'hF, $urandom, -1, 1'b0, 32'h0);

      // full-word write then read, no wait states
      access(0, 32'h10, 4'hF, 32'hDEADBEEF, -1, 1'b0, 32'h0);
      access(0, 32'h10, 4'h0, 32'h0, -1, 1'b1, 32'hDEADBEEF);

      // single byte lane merge
      access(0, 32'h20, 4'hF, 32'h11223344, -1, 1'b0, 32'h0);
      access(0, 32'h20, 4'b0100, 32'h00AA0000, -1, 1'b0, 32'h0);
      access(0, 32'h20, 4'h0, 32'h0, -1, 1'b1, 32'h11AA3344);

      // three wait states: same lane merge through the slow instance
      access(1, 32'h20, 4'hF, 32'h11223344, -1, 1'b0, 32'h0);
      access(1, 32'h20, 4'b0001, 32'h000000EE, -1, 1'b0, 32'h0);
      access(1, 32'h20, 4'h0, 32'h0, -1, 1'b1, 32'h112233EE);

      // flush during WAIT abandons the write
      access(1, 32'h30, 4'hF, 32'h55667788, -1, 1'b0, 32'h0);
      access(1, 32'h30, 4'hF, 32'hCAFEF00D, 1, 1'b0, 32'h0);
      idle_cycle();
      access(1, 32'h30, 4'h0, 32'h0, -1, 1'b1, 32'h55667788);

      // reset while a write sits in WAIT
      access(1, 32'h34, 4'hF, 32'h0C0FFEE0, -1, 1'b0, 32'h0);
      drive(1, 1'b1, 4'hF, 32'h34, 32'h99999999);
      push(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midwait_rst_stall", 32'(stall[1]), 32'd0);
      check("midwait_rst_resp_valid", 32'(rv[1]), 32'd0);
      check("midwait_rst_read_data1", rdata[1], 32'h0);
      check("midwait_rst_read_data0", rdata[0], 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      access(1, 32'h34, 4'h0, 32'h0, -1, 1'b1, 32'h0C0FFEE0);

      // out-of-range address: aliases to word 0, or is rejected with ERR_EN
      access(0, 32'h0, 4'hF, 32'h12345678, -1, 1'b0, 32'h0);
      access(0, 32'h00001000, 4'hF, 32'h0BADC0DE, -1, 1'b0, 32'h0);
      access(0, 32'h0, 4'h0, 32'h0, -1, 1'b1, ERR_BUILD ? 32'h12345678 : 32'h0BADC0DE);

      // randomized mix of reads, partial writes, flushes, gaps and high addresses
      repeat (300) begin
         sel = int'($urandom_range(0, 1));
         idx = 10'($urandom_range(0, 63));
         lo  = 2'($urandom_range(0, 3));
         hi  = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h0;
         a   = {hi, idx, lo};
         w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         fl  = (sel == 1 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : -1;
         access(sel, a, w, $urandom, fl, 1'b0, 32'h0);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      idle_cycle();
      idle_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
